// File: rtl/uart_prog_loader_pkg.sv
// Shared types and defaults for the UART program loader and its RX core.
package uart_prog_loader_pkg;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Cleared instruction memory reads as NOP
  localparam logic [7:0] NOP_OPCODE = 8'h00;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Fetch-side bundle between the PC/decoder and the program loader.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] instr_out;
  logic              load_done;
  logic              cpu_hold;

  // PC side: issues fetch addresses, consumes instructions and hold
  modport master (output pc_addr, input instr_out, load_done, cpu_hold);
  // Loader side: serves instructions and load status
  modport slave  (input pc_addr, output instr_out, load_done, cpu_hold);
endinterface

// File: rtl/uart_prog_loader_rx_core.sv
// UART receiver: 2-FF synchroniser, start/data/stop FSM, LSB-first shift register.
// Emits a 1-cycle valid with the byte on a good stop bit, or a 1-cycle frame
// error pulse on a bad one. Everything freezes while ena is low.
module uart_rx_core
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              rx_ferr
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  rx_state_t         state;
  logic              rx_meta, rx_s, rx_s_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;

  // Synchronise rx, track bit timing and assemble frames
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_s_d   <= 1'b1;
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else if (ena) begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_s_d   <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          // Only a genuine high-to-low edge starts a frame
          if (rx_s_d && !rx_s) begin
            state    <= RX_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_W-1:1]};
            bit_cnt  <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
            if (rx_s) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: writes UART-received bytes into a small instruction memory,
// serves registered fetches, and holds the CPU until the memory is full once.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              rx,
  uart_prog_loader_if.slave fetch,
  output logic              frame_err,
  output logic              rx_byte_ok
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] instr_q;
  logic              load_done_q;
  logic [DATA_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_rx_core (
    .clock    (clock),
    .reset    (reset),
    .ena      (ena),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // Memory write, write pointer, sticky status and registered fetch read
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(NOP_OPCODE);
      wptr        <= '0;
      instr_q     <= '0;
      load_done_q <= 1'b0;
      frame_err   <= 1'b0;
      rx_byte_ok  <= 1'b0;
    end else if (ena) begin
      // Read sees pre-write contents when addresses collide
      instr_q    <= mem[fetch.pc_addr];
      rx_byte_ok <= rx_valid;
      if (rx_valid) begin
        mem[wptr] <= rx_byte;
        wptr      <= wptr + ADDR_W'(1);
        if (wptr == '1) load_done_q <= 1'b1;
      end
      if (rx_ferr) frame_err <= 1'b1;
    end
  end

  assign fetch.instr_out = instr_q;
  assign fetch.load_done = load_done_q;
  assign fetch.cpu_hold  = ~load_done_q;

endmodule
